// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
//   state_t    : sequencer states
//   DEF_WIDTH  : default operand / quotient width
//   DEF_FRAC   : default fractional bit count
//   ni_of      : iteration count (dividend width) for a given WIDTH/FRAC
//   cnt_w_of   : iteration counter width for a given iteration count
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_FRAC  = 4;

  // Dividend is n<<FRAC, so one iteration per dividend bit.
  function automatic int unsigned ni_of(input int unsigned width, input int unsigned frac);
    return width + frac;
  endfunction

  function automatic int unsigned cnt_w_of(input int unsigned ni);
    return (ni <= 1) ? 1 : $clog2(ni);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration.
//   rem        : partial remainder entering the iteration (always < divisor)
//   d          : divisor
//   dbit       : next dividend bit, shifted into the remainder LSB
//   rem_next_c : partial remainder leaving the iteration
//   q_bit_c    : quotient bit produced by this iteration
module restoring_div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] d,
  input  logic             dbit,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem, dbit};

  // Subtract succeeds when the shifted remainder reaches the divisor. The
  // difference is then < d, so only the low WIDTH bits are ever significant.
  assign q_bit_c    = (shifted >= {1'b0, d});
  assign rem_next_c = q_bit_c ? (shifted[WIDTH-1:0] - d) : shifted[WIDTH-1:0];

endmodule

// File: rtl/restoring_div_seq.sv
// Multi-cycle unsigned fixed-point restoring divider, one quotient bit per clock.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : request strobe, sampled only in IDLE
//   n, d     : numerator / denominator, Q(WIDTH-FRAC).FRAC, captured on acceptance
//   busy     : operation in progress (acceptance through last iteration)
//   done     : one-cycle pulse when results become valid
//   q        : quotient (truncated, saturated on overflow / divide-by-zero)
//   rem      : final partial remainder of (n<<FRAC)/d
//   ovf, dbz : quotient overflow / zero divisor flags
module restoring_div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem,
  output logic             ovf,
  output logic             dbz
);

  localparam int unsigned NI    = ni_of(WIDTH, FRAC);
  localparam int unsigned CNT_W = cnt_w_of(NI);
  localparam logic [WIDTH-1:0] Q_SAT = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] d_r;
  logic [NI-1:0]    dvd;
  logic [NI-1:0]    qf;

  logic [WIDTH-1:0] part_next_c;
  logic             q_bit_c;
  logic [NI-1:0]    qf_next_c;

  // Shared shift/subtract/restore datapath; dividend consumed MSB first.
  restoring_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem        (part),
    .d          (d_r),
    .dbit       (dvd[NI-1]),
    .rem_next_c (part_next_c),
    .q_bit_c    (q_bit_c)
  );

  assign qf_next_c = {qf[NI-2:0], q_bit_c};

  // Sequencer, operand registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      part  <= '0;
      d_r   <= '0;
      dvd   <= '0;
      qf    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_r  <= d;
            dvd  <= NI'(n) << FRAC;
            part <= '0;
            qf   <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b0;
            if (d == '0) begin
              // No iterations needed: report saturation immediately.
              q     <= Q_SAT;
              rem   <= '0;
              dbz   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= ITER;
            end
          end
        end

        ITER: begin
          part <= part_next_c;
          qf   <= qf_next_c;
          dvd  <= {dvd[NI-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NI - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            rem   <= part_next_c;
            state <= DONE;
            // Any quotient bit above WIDTH means the integer part overflowed.
            if (|qf_next_c[NI-1:WIDTH]) begin
              q   <= Q_SAT;
              ovf <= 1'b1;
            end else begin
              q   <= qf_next_c[WIDTH-1:0];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
